// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_ctrl peripheral: TX FSM states, CON bit map,
// register offsets and the transmitter start timeout.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_END
    } tx_state_t;

    localparam int unsigned CON_TX_IE      = 0;
    localparam int unsigned CON_RX_IE      = 1;
    localparam int unsigned CON_TX_DONE    = 2;
    localparam int unsigned CON_RX_VALID   = 3;
    localparam int unsigned CON_FIFO_FULL  = 4;
    localparam int unsigned CON_FIFO_EMPTY = 5;
    localparam int unsigned CON_TX_OVF     = 6;
    localparam int unsigned CON_RX_OVR     = 7;
    localparam int unsigned CON_TX_ERR     = 8;
    localparam int unsigned CON_BUSY       = 9;
    localparam int unsigned CON_LB         = 10;

    localparam logic [31:0] OFS_TXD = 32'd0;
    localparam logic [31:0] OFS_RXD = 32'd4;
    localparam logic [31:0] OFS_CON = 32'd8;

    localparam int unsigned TX_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; DEPTH must be a power of two
// so the pointers wrap naturally. Callers only pop when non-empty.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX FIFO + start/handshake FSM, RX capture, CON flags, irq.
// Optional loopback of transmitted bytes into RX is enabled by `define UART_CTRL_LOOPBACK_EN.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_status,
    input  logic        tx_end,
    input  logic [7:0]  rx_data,
    input  logic        rx_status
);
    localparam int unsigned CW   = $clog2(TX_DEPTH) + 1;
    localparam int unsigned TO_W = $clog2(TX_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TX_TIMEOUT - 1);

    tx_state_t       state, state_n;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      fifo_dout;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic            tx_ie, rx_ie, tx_done, rx_valid, tx_ovf, rx_ovr, tx_err;
    logic [7:0]      rx_reg;
    logic            rx_evt, lb_bit;
    logic [7:0]      rx_byte;
    logic [31:0]     con_val;

    wire sel_txd = (addr == BASE_ADDR + OFS_TXD);
    wire sel_rxd = (addr == BASE_ADDR + OFS_RXD);
    wire sel_con = (addr == BASE_ADDR + OFS_CON);
    wire wr_txd  = wr & sel_txd;
    wire wr_con  = wr & sel_con;
    wire rd_rxd  = rd & sel_rxd;
    wire rd_con  = rd & sel_con;

    // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    assign fifo_pop  = (state == ST_LOAD);
    assign fifo_push = wr_txd & (~fifo_full | fifo_pop);
    wire ovf_evt     = wr_txd & fifo_full & ~fifo_pop;
    wire timeout_evt = (state == ST_WAIT_BUSY) & tx_status & (to_cnt == TO_MAX);
    wire done_evt    = (state == ST_WAIT_END) & tx_end;

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:      if (!fifo_empty && tx_status) state_n = ST_LOAD;
            ST_LOAD:      state_n = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!tx_status) state_n = ST_WAIT_END;
                          else if (to_cnt == TO_MAX) state_n = ST_IDLE;
            ST_WAIT_END:  if (tx_end) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    // tx_en is registered alongside tx_data so the byte is stable for the whole pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            to_cnt <= (state == ST_WAIT_BUSY) ? to_cnt + 1'b1 : '0;
            tx_en  <= (state == ST_LOAD);
            if (state == ST_LOAD) tx_data <= fifo_dout;
        end
    end

`ifdef UART_CTRL_LOOPBACK_EN
    logic lb;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         lb <= 1'b0;
        else if (wr_con) lb <= wdata[CON_LB];
    end
    assign lb_bit  = lb;
    assign rx_evt  = lb ? tx_end  : rx_status;
    assign rx_byte = lb ? tx_data : rx_data;
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:11], wdata[9:8]};
`else
    assign lb_bit  = 1'b0;
    assign rx_evt  = rx_status;
    assign rx_byte = rx_data;
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:8]};
`endif

    // Set events take priority over the read-to-clear of the sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            tx_done  <= 1'b0;
            tx_ovf   <= 1'b0;
            tx_err   <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_valid <= 1'b0;
            rx_reg   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_con) begin
                tx_ie <= wdata[CON_TX_IE];
                rx_ie <= wdata[CON_RX_IE];
            end
            if (done_evt)    tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
            if (ovf_evt)     tx_ovf <= 1'b1;
            else if (rd_con) tx_ovf <= 1'b0;
            if (timeout_evt) tx_err <= 1'b1;
            else if (rd_con) tx_err <= 1'b0;
            if (rx_evt && rx_valid && !rd_rxd) rx_ovr <= 1'b1;
            else if (rd_con)                   rx_ovr <= 1'b0;
            if (rx_evt)      rx_valid <= 1'b1;
            else if (rd_rxd) rx_valid <= 1'b0;
            if (rx_evt)      rx_reg <= rx_byte;
            irq <= (tx_ie & tx_done) | (rx_ie & rx_valid);
        end
    end

    always_comb begin
        con_val                 = '0;
        con_val[CON_TX_IE]      = tx_ie;
        con_val[CON_RX_IE]      = rx_ie;
        con_val[CON_TX_DONE]    = tx_done;
        con_val[CON_RX_VALID]   = rx_valid;
        con_val[CON_FIFO_FULL]  = fifo_full;
        con_val[CON_FIFO_EMPTY] = fifo_empty;
        con_val[CON_TX_OVF]     = tx_ovf;
        con_val[CON_RX_OVR]     = rx_ovr;
        con_val[CON_TX_ERR]     = tx_err;
        con_val[CON_BUSY]       = (state != ST_IDLE);
        con_val[CON_LB]         = lb_bit;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)      rdata = 32'(fifo_count);
            else if (sel_rxd) rdata = {24'b0, rx_reg};
            else if (sel_con) rdata = con_val;
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl with a behavioural transmitter model
// and a scoreboard queue of bytes expected on tx_en.
module tb_uart_ctrl;
    localparam logic [31:0] TXD = 32'h40000018;
    localparam logic [31:0] RXD = 32'h4000001C;
    localparam logic [31:0] CON = 32'h40000020;
    localparam int M_NORMAL = 0;
    localparam int M_HOLD   = 1;
    localparam int M_STUCK  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        rd, wr, irq, tx_en, tx_status, tx_end, rx_status;
    logic [7:0]  tx_data, rx_data;

    int tests = 0;
    int failed = 0;
    int tx_en_cnt = 0;
    int tx_end_cnt = 0;
    int cyc = 0;
    int last_en_cyc = 0;
    int mode = M_NORMAL;
    int busy_len = 5;
    logic [7:0] exp_q[$];

    uart_ctrl #(.TX_DEPTH(4), .BASE_ADDR(32'h40000018)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .tx_en(tx_en), .tx_data(tx_data),
        .tx_status(tx_status), .tx_end(tx_end), .rx_data(rx_data), .rx_status(rx_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] v);
        addr = a; rd = 1'b1;
        #1 v = rdata;
        tick();
        rd = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back(b);
        cpu_write(TXD, {24'b0, b});
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d; rx_status = 1'b1;
        tick();
        rx_status = 1'b0;
    endtask

    // Transmitter model: drops idle after tx_en, stays busy busy_len cycles, then pulses tx_end.
    initial begin
        tx_status = 1'b1;
        tx_end = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (mode == M_HOLD) tx_status = 1'b0;
            else if (mode == M_STUCK) tx_status = 1'b1;
            else if (tx_en === 1'b1) begin
                tx_status = 1'b0;
                repeat (busy_len) @(posedge clk);
                #3;
                tx_end = 1'b1; tx_status = 1'b1; tx_end_cnt++;
                @(posedge clk);
                #3;
                tx_end = 1'b0;
            end else tx_status = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_en === 1'b1) begin
                tx_en_cnt++;
                last_en_cyc = cyc;
                check("tx_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int base, c1;
        rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; rx_data = '0; rx_status = 1'b0;
        repeat (3) tick();
        check("rst_tx_en", {31'b0, tx_en}, 0);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        rst = 1'b0;
        tick();
        cpu_read(CON, v); check("rst_con", v, 32'h20);
        cpu_read(TXD, v); check("rst_txd", v, 0);
        cpu_read(RXD, v); check("rst_rxd", v, 0);

        // single byte, tx_en latency and tx_done read-clear
        send(8'h55, 1);
        check("t1_en_d0", {31'b0, tx_en}, 0);
        tick(); check("t1_en_d1", {31'b0, tx_en}, 0);
        tick(); check("t1_en_d2", {31'b0, tx_en}, 1);
        tick(); check("t1_en_d3", {31'b0, tx_en}, 0);
        v = '0;
        for (int i = 0; i < 40 && !v[2]; i++) cpu_read(CON, v);
        check("t1_done", {31'b0, v[2]}, 1);
        cpu_read(CON, v); check("t1_done_clr", v, 32'h20);

        // overflow with transmitter held busy
        mode = M_HOLD;
        tick(); tick();
        for (int i = 1; i <= 5; i++) send(8'(i), i <= 4);
        cpu_read(TXD, v); check("t2_count", v, 4);
        cpu_read(CON, v); check("t2_con_full_ovf", v, 32'h50);
        base = tx_end_cnt;
        mode = M_NORMAL;
        for (int i = 0; i < 200 && tx_end_cnt < base + 4; i++) tick();
        check("t2_sent", 32'(tx_end_cnt - base), 4);
        check("t2_q_empty", 32'(exp_q.size()), 0);
        repeat (3) tick();
        cpu_read(CON, v); check("t2_con_done", v, 32'h24);

        // RX capture and irq
        cpu_write(CON, 32'h2);
        rx_pulse(8'hA3);
        check("t3_irq_d0", {31'b0, irq}, 0);
        tick(); check("t3_irq_d1", {31'b0, irq}, 1);
        cpu_read(RXD, v); check("t3_rxd", v, 32'hA3);
        check("t3_irq_hold", {31'b0, irq}, 1);
        cpu_read(CON, v); check("t3_con", v, 32'h22);
        check("t3_irq_fall", {31'b0, irq}, 0);
        cpu_write(CON, 32'h0);

        // overrun, then read coinciding with the second byte
        rx_pulse(8'h11); tick(); rx_pulse(8'h22);
        cpu_read(CON, v); check("t4_con_ovr", v, 32'hA8);
        cpu_read(RXD, v); check("t4_rxd", v, 32'h22);
        rx_pulse(8'h11);
        rx_data = 8'h22; rx_status = 1'b1; addr = RXD; rd = 1'b1;
        #1 v = rdata; check("t4_rd_old", v, 32'h11);
        tick();
        rx_status = 1'b0; rd = 1'b0;
        cpu_read(CON, v); check("t4_con_no_ovr", v, 32'h28);
        cpu_read(RXD, v); check("t4_rxd_new", v, 32'h22);

        // start timeout
        mode = M_STUCK;
        tick();
        base = tx_en_cnt;
        send(8'h77, 1); send(8'h88, 1);
        for (int i = 0; i < 20 && tx_en_cnt < base + 1; i++) tick();
        c1 = last_en_cyc;
        for (int i = 0; i < 40 && tx_en_cnt < base + 2; i++) tick();
        check("t5_en_count", 32'(tx_en_cnt - base), 2);
        check("t5_gap", 32'(last_en_cyc - c1), 18);
        cpu_read(CON, v); check("t5_con_err_busy", v, 32'h320);
        repeat (25) tick();
        cpu_read(CON, v); check("t5_con_err_idle", v, 32'h120);
        cpu_read(CON, v); check("t5_con_clr", v, 32'h20);
        mode = M_NORMAL;
        tick();

        // asynchronous reset while tx_en is high
        send(8'h99, 1);
        for (int i = 0; i < 10 && tx_en !== 1'b1; i++) tick();
        check("t6_en_high", {31'b0, tx_en}, 1);
        #1 rst = 1'b1;
        #1 check("t6_async_en", {31'b0, tx_en}, 0);
        check("t6_async_data", {24'b0, tx_data}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // reset in WAIT_END with three bytes queued
        busy_len = 60;
        base = tx_en_cnt;
        send(8'hA1, 1); send(8'hA2, 1); send(8'hA3, 1); send(8'hA4, 1);
        for (int i = 0; i < 20 && tx_en_cnt < base + 1; i++) tick();
        repeat (4) tick();
        cpu_read(TXD, v); check("t7_queued", v, 3);
        cpu_read(CON, v); check("t7_con_busy", v, 32'h200);
        #1 rst = 1'b1;
        addr = TXD; rd = 1'b1;
        #1 check("t7_rst_txd", rdata, 0);
        addr = CON;
        #1 check("t7_rst_con", rdata, 32'h20);
        check("t7_rst_en", {31'b0, tx_en}, 0);
        rd = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        base = tx_en_cnt;
        repeat (80) tick();
        check("t7_no_tx", 32'(tx_en_cnt - base), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
